// File: rtl/icache_pkg.sv
// Shared defaults, derived widths and flush-state type for the instruction-cache way array.
package icache_pkg;

  localparam int DEF_INDEX_SIZE    = 6;
  localparam int DEF_WORD_OFF_SIZE = 4;
  localparam int DEF_TAG_SIZE      = 20;
  localparam int DEF_NUM_WAYS      = 2;

  function automatic int line_bits(input int word_off_size);
    return 32 * (2 ** word_off_size);
  endfunction

  function automatic int way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  // A 1-way cache still keeps one dummy PLRU bit so no vector collapses to zero width.
  function automatic int plru_w(input int num_ways);
    return (num_ways > 1) ? num_ways - 1 : 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/icache_plru.sv
// Tree pseudo-LRU for one set: heap-ordered node bits (node n has children 2n+1, 2n+2),
// a bit value of 0 steers the victim walk to the left subtree.
module icache_plru
  import icache_pkg::*;
#(
  parameter int  NUM_WAYS = DEF_NUM_WAYS,
  localparam int WAY_W    = way_w(NUM_WAYS),
  localparam int PLRU_W   = plru_w(NUM_WAYS)
) (
  input  logic [PLRU_W-1:0] bits,
  input  logic [WAY_W-1:0]  access_way,
  input  logic              access_valid,
  output logic [PLRU_W-1:0] bits_next,
  output logic [WAY_W-1:0]  victim
);

  if (NUM_WAYS == 1) begin : g_single
    logic unused_inputs;
    assign unused_inputs = ^{bits, access_way, access_valid};
    assign bits_next     = '0;
    assign victim        = '0;
  end else begin : g_tree
    logic [NUM_WAYS-1:0] way_sel;

    // A way is the victim when every node on its path points towards it.
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      logic [WAY_W-1:0] lvl_ok;
      for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
        localparam int   NODE = (1 << l) - 1 + (w >> (WAY_W - l));
        localparam logic DIR  = 1'((w >> (WAY_W - 1 - l)) & 1);
        assign lvl_ok[l] = (bits[NODE] == DIR);
      end
      assign way_sel[w] = &lvl_ok;
    end

    always_comb begin
      // NOTE: combinational outputs get a default before any conditional write so no latch is inferred.
      victim = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (way_sel[w]) victim = WAY_W'(w);
      end
    end

    // Nodes on the accessed way's path flip to point away from it.
    for (genvar l = 0; l < WAY_W; l++) begin : g_upd_lvl
      for (genvar p = 0; p < (1 << l); p++) begin : g_upd_pos
        localparam int               NODE = (1 << l) - 1 + p;
        localparam logic [WAY_W-1:0] POS  = WAY_W'(p);
        assign bits_next[NODE] = (access_valid && ((access_way >> (WAY_W - l)) == POS))
                               ? ~access_way[WAY_W-1-l] : bits[NODE];
      end
    end
  end

endmodule

// File: rtl/icache_way_array.sv
// N-way set-associative tag/data/valid store: one-cycle registered lookup, PLRU-victim refill
// and a one-set-per-cycle flush sweep.
module icache_way_array
  import icache_pkg::*;
#(
  parameter int  INDEX_SIZE    = DEF_INDEX_SIZE,
  parameter int  WORD_OFF_SIZE = DEF_WORD_OFF_SIZE,
  parameter int  TAG_SIZE      = DEF_TAG_SIZE,
  parameter int  NUM_WAYS      = DEF_NUM_WAYS,
  localparam int LINE_BITS     = line_bits(WORD_OFF_SIZE),
  localparam int WAY_W         = way_w(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [INDEX_SIZE-1:0] rd_index,
  input  logic [TAG_SIZE-1:0]   rd_tag,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [WAY_W-1:0]      resp_way,
  output logic [LINE_BITS-1:0]  resp_line,
  input  logic                  wr_en,
  input  logic [INDEX_SIZE-1:0] wr_index,
  input  logic [TAG_SIZE-1:0]   wr_tag,
  input  logic [LINE_BITS-1:0]  wr_line,
  output logic [WAY_W-1:0]      victim_way,
  input  logic                  flush_req,
  output logic                  flush_busy
);

  localparam int SETS   = 2 ** INDEX_SIZE;
  localparam int PLRU_W = plru_w(NUM_WAYS);

  flush_state_t          state;
  logic [INDEX_SIZE-1:0] flush_cnt;
  logic                  rd_acc, wr_acc;

  logic [TAG_SIZE-1:0]   tag_mem  [NUM_WAYS][SETS];
  logic [LINE_BITS-1:0]  data_mem [NUM_WAYS][SETS];
  logic [SETS-1:0]       valid    [NUM_WAYS];
  logic [PLRU_W-1:0]     plru     [SETS];

  logic [INDEX_SIZE-1:0] rd_index_q;
  logic [TAG_SIZE-1:0]   rd_tag_q;
  logic [TAG_SIZE-1:0]   tag_q    [NUM_WAYS];
  logic [LINE_BITS-1:0]  line_q   [NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_q;
  logic [NUM_WAYS-1:0]   match;

  logic [PLRU_W-1:0]     plru_wr_next, plru_hit_next;
  logic [WAY_W-1:0]      unused_hit_victim;

  assign rd_acc = rd_en && (state == IDLE);
  assign wr_acc = wr_en && (state == IDLE);

  icache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru_wr (
    .bits         (plru[wr_index]),
    .access_way   (victim_way),
    .access_valid (wr_acc),
    .bits_next    (plru_wr_next),
    .victim       (victim_way)
  );

  icache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru_hit (
    .bits         (plru[rd_index_q]),
    .access_way   (resp_way),
    .access_valid (resp_hit),
    .bits_next    (plru_hit_next),
    .victim       (unused_hit_victim)
  );

  // NOTE: tag/data storage and its read registers carry no reset; valid bits qualify every use.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (wr_acc && (victim_way == WAY_W'(w))) begin
        tag_mem[w][wr_index]  <= wr_tag;
        data_mem[w][wr_index] <= wr_line;
      end
      if (rd_acc) begin
        tag_q[w]  <= tag_mem[w][rd_index];
        line_q[w] <= data_mem[w][rd_index];
      end
    end
    if (rd_acc) begin
      rd_index_q <= rd_index;
      rd_tag_q   <= rd_tag;
    end
  end

  // Later assignments win: refill beats hit, flush clear beats both on the same set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      flush_busy <= 1'b0;
      resp_valid <= 1'b0;
      valid_q    <= '0;
      for (int w = 0; w < NUM_WAYS; w++) valid[w] <= '0;
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      resp_valid <= rd_acc;
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (rd_acc) valid_q[w] <= valid[w][rd_index];
        if (wr_acc && (victim_way == WAY_W'(w))) valid[w][wr_index] <= 1'b1;
      end
      if (resp_hit) plru[rd_index_q] <= plru_hit_next;
      if (wr_acc)   plru[wr_index]   <= plru_wr_next;

      case (state)
        IDLE: begin
          if (flush_req) begin
            state      <= FLUSH;
            flush_cnt  <= '0;
            flush_busy <= 1'b1;
          end
        end
        FLUSH: begin
          for (int w = 0; w < NUM_WAYS; w++) valid[w][flush_cnt] <= 1'b0;
          plru[flush_cnt] <= '0;
          flush_cnt       <= flush_cnt + 1'b1;
          if (flush_cnt == INDEX_SIZE'(SETS - 1)) begin
            state      <= IDLE;
            flush_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lowest matching way wins if more than one way ever matches.
  always_comb begin
    resp_way  = '0;
    resp_line = '0;
    for (int w = 0; w < NUM_WAYS; w++) match[w] = valid_q[w] && (tag_q[w] == rd_tag_q);
    resp_hit = resp_valid && (|match);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (resp_valid && match[w]) begin
        resp_way  = WAY_W'(w);
        resp_line = line_q[w];
      end
    end
  end

endmodule

// File: tb/tb_icache_way_array.sv
// Directed bench: a 2-way instance for lookup/refill/flush/reset, a 4-way instance for tree PLRU order.
module tb_icache_way_array;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         rd_en, wr_en, flush_req;
  logic [5:0]   rd_index, wr_index;
  logic [19:0]  rd_tag, wr_tag;
  logic [511:0] wr_line;
  logic         resp_valid, resp_hit, flush_busy;
  logic [0:0]   resp_way, victim_way;
  logic [511:0] resp_line;

  logic         rd_en4, wr_en4, flush_req4;
  logic [5:0]   rd_index4, wr_index4;
  logic [19:0]  rd_tag4, wr_tag4;
  logic [511:0] wr_line4;
  logic         resp_valid4, resp_hit4, flush_busy4;
  logic [1:0]   resp_way4, victim_way4;
  logic [511:0] resp_line4;

  int checks = 0;
  int errors = 0;

  localparam logic [511:0] L0 = {16{32'hA0A0_0000}};
  localparam logic [511:0] L1 = {16{32'hB1B1_1111}};

  icache_way_array #(.NUM_WAYS(2)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_index(rd_index), .rd_tag(rd_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_line(resp_line),
    .wr_en(wr_en), .wr_index(wr_index), .wr_tag(wr_tag), .wr_line(wr_line),
    .victim_way(victim_way), .flush_req(flush_req), .flush_busy(flush_busy)
  );

  icache_way_array #(.NUM_WAYS(4)) dut4 (
    .clk(clk), .reset(reset),
    .rd_en(rd_en4), .rd_index(rd_index4), .rd_tag(rd_tag4),
    .resp_valid(resp_valid4), .resp_hit(resp_hit4), .resp_way(resp_way4), .resp_line(resp_line4),
    .wr_en(wr_en4), .wr_index(wr_index4), .wr_tag(wr_tag4), .wr_line(wr_line4),
    .victim_way(victim_way4), .flush_req(flush_req4), .flush_busy(flush_busy4)
  );

  // Drivers start and end on a falling edge; the response is visible on return.
  task automatic do_lookup(input logic [5:0] idx, input logic [19:0] tag);
    rd_en = 1'b1; rd_index = idx; rd_tag = tag;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_refill(input logic [5:0] idx, input logic [19:0] tag, input logic [511:0] line);
    wr_en = 1'b1; wr_index = idx; wr_tag = tag; wr_line = line;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_lookup4(input logic [5:0] idx, input logic [19:0] tag);
    rd_en4 = 1'b1; rd_index4 = idx; rd_tag4 = tag;
    @(negedge clk);
    rd_en4 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_hit !== 1'b0) begin errors++; $display("FAIL reset_resp_hit got %b want 0", resp_hit); end
    checks++; if (resp_way !== 1'b0) begin errors++; $display("FAIL reset_resp_way got %0d want 0", resp_way); end
    checks++; if (resp_line !== '0) begin errors++; $display("FAIL reset_resp_line got %h want 0", resp_line); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_flush_busy got %b want 0", flush_busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_miss;
    do_lookup(6'd5, 20'h12345);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL miss_valid got %b want 1", resp_valid); end
    checks++; if (resp_hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b want 0", resp_hit); end
    checks++; if (resp_way !== 1'b0) begin errors++; $display("FAIL miss_way got %0d want 0", resp_way); end
    checks++; if (resp_line !== '0) begin errors++; $display("FAIL miss_line got %h want 0", resp_line); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", resp_valid); end
  endtask

  task automatic test_refill_hit;
    wr_index = 6'd5; #1;
    checks++; if (victim_way !== 1'b0) begin errors++; $display("FAIL victim_first got %0d want 0", victim_way); end
    do_refill(6'd5, 20'hAAAAA, L0);
    #1;
    checks++; if (victim_way !== 1'b1) begin errors++; $display("FAIL victim_second got %0d want 1", victim_way); end
    do_refill(6'd5, 20'hBBBBB, L1);
    do_lookup(6'd5, 20'hBBBBB);
    checks++; if (resp_hit !== 1'b1 || resp_way !== 1'b1) begin errors++; $display("FAIL hit_b got hit=%b way=%0d want hit=1 way=1", resp_hit, resp_way); end
    checks++; if (resp_line !== L1) begin errors++; $display("FAIL hit_b_line got %h want %h", resp_line, L1); end
    do_lookup(6'd5, 20'hAAAAA);
    checks++; if (resp_hit !== 1'b1 || resp_way !== 1'b0) begin errors++; $display("FAIL hit_a got hit=%b way=%0d want hit=1 way=0", resp_hit, resp_way); end
    checks++; if (resp_line !== L0) begin errors++; $display("FAIL hit_a_line got %h want %h", resp_line, L0); end
    @(negedge clk);
    wr_index = 6'd5; #1;
    checks++; if (victim_way !== 1'b1) begin errors++; $display("FAIL victim_after_hits got %0d want 1", victim_way); end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    rd_en = 1'b1; rd_index = 6'd9; rd_tag = 20'h00001;
    wr_en = 1'b1; wr_index = 6'd9; wr_tag = 20'h00001; wr_line = L1;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin errors++; $display("FAIL rbw_miss got valid=%b hit=%b want valid=1 hit=0", resp_valid, resp_hit); end
    do_lookup(6'd9, 20'h00001);
    checks++; if (resp_hit !== 1'b1 || resp_way !== 1'b0) begin errors++; $display("FAIL rbw_then_hit got hit=%b way=%0d want hit=1 way=0", resp_hit, resp_way); end
    checks++; if (resp_line !== L1) begin errors++; $display("FAIL rbw_line got %h want %h", resp_line, L1); end
  endtask

  task automatic test_flush;
    int n;
    for (int i = 0; i < 64; i++) do_refill(6'(i), 20'(32'h100 + i), {16{32'(i)}});
    do_lookup(6'd63, 20'h0013F);
    checks++; if (resp_hit !== 1'b1) begin errors++; $display("FAIL prefill_hit got %b want 1", resp_hit); end
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    n = 0;
    while (flush_busy === 1'b1 && n < 200) begin
      n++;
      if (n == 10) begin
        rd_en = 1'b1; rd_index = 6'd63; rd_tag = 20'h0013F;
        wr_en = 1'b1; wr_index = 6'd3; wr_tag = 20'h77777; wr_line = L1;
      end else begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
      if (n == 11) begin
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_ignored got valid=%b want 0", resp_valid); end
      end
      @(negedge clk);
    end
    rd_en = 1'b0; wr_en = 1'b0;
    checks++; if (n != 64) begin errors++; $display("FAIL flush_busy_len got %0d cycles want 64", n); end
    do_lookup(6'd3, 20'h77777);
    checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin errors++; $display("FAIL flush_wr_ignored got valid=%b hit=%b want valid=1 hit=0", resp_valid, resp_hit); end
    for (int i = 0; i <= 64; i++) begin
      if (i > 0) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin errors++; $display("FAIL post_flush_miss set %0d got valid=%b hit=%b want valid=1 hit=0", i - 1, resp_valid, resp_hit); end
      end
      if (i < 64) begin
        rd_en = 1'b1; rd_index = 6'(i); rd_tag = 20'(32'h100 + i); wr_index = 6'(i);
        #1;
        checks++; if (victim_way !== 1'b0) begin errors++; $display("FAIL post_flush_victim set %0d got %0d want 0", i, victim_way); end
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_flush;
    do_refill(6'd40, 20'h40404, L0);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    repeat (19) @(negedge clk);
    checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL mid_flush_busy got %b want 1", flush_busy); end
    reset = 1'b1;
    #1;
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b want 0", flush_busy); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b want 0", resp_valid); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_lookup(6'd40, 20'h40404);
    checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin errors++; $display("FAIL after_reset_miss got valid=%b hit=%b want valid=1 hit=0", resp_valid, resp_hit); end
  endtask

  task automatic test_plru4;
    logic [1:0] fill_order [4];
    fill_order = '{2'd0, 2'd2, 2'd1, 2'd3};
    for (int i = 0; i < 4; i++) begin
      wr_index4 = 6'd2; #1;
      checks++; if (victim_way4 !== fill_order[i]) begin errors++; $display("FAIL plru4_fill_victim %0d got %0d want %0d", i, victim_way4, fill_order[i]); end
      wr_en4 = 1'b1; wr_tag4 = 20'hA0 + 20'(fill_order[i]); wr_line4 = {16{32'(fill_order[i])}};
      @(negedge clk);
      wr_en4 = 1'b0;
    end
    for (int w = 0; w < 4; w++) begin
      do_lookup4(6'd2, 20'hA0 + 20'(w));
      checks++; if (resp_hit4 !== 1'b1 || resp_way4 !== 2'(w)) begin errors++; $display("FAIL plru4_hit %0d got hit=%b way=%0d", w, resp_hit4, resp_way4); end
    end
    @(negedge clk);
    wr_index4 = 6'd2; #1;
    checks++; if (victim_way4 !== 2'd0) begin errors++; $display("FAIL plru4_victim_a got %0d want 0", victim_way4); end
    do_lookup4(6'd2, 20'hA0);
    checks++; if (resp_line4 !== {16{32'd0}}) begin errors++; $display("FAIL plru4_line got %h want 0", resp_line4); end
    @(negedge clk);
    #1;
    checks++; if (victim_way4 !== 2'd2) begin errors++; $display("FAIL plru4_victim_b got %0d want 2", victim_way4); end
  endtask

  initial begin
    reset = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; flush_req = 1'b0;
    rd_index = '0; wr_index = '0; rd_tag = '0; wr_tag = '0; wr_line = '0;
    rd_en4 = 1'b0; wr_en4 = 1'b0; flush_req4 = 1'b0;
    rd_index4 = '0; wr_index4 = '0; rd_tag4 = '0; wr_tag4 = '0; wr_line4 = '0;
    test_reset;
    test_cold_miss;
    test_refill_hit;
    test_same_cycle;
    test_flush;
    test_reset_mid_flush;
    test_plru4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_way_array.md
Name: icache_way_array

Overview:
- Parametrised N-way set-associative tag/data/valid storage for the instruction cache; successor to the single-way direct-mapped line RAM.
- Provides a registered lookup port with per-way tag compare and hit-way encode, and a refill port that writes the tree-PLRU victim way.
- Provides a multi-cycle flush sequencer that sweeps all sets clearing valid and PLRU state.
- Sits between the ICache control FSM (lookup/refill/flush requests) and the AXI refill path.

Parameters:
- INDEX_SIZE, 6, set index width; SETS = 2**INDEX_SIZE.
- WORD_OFF_SIZE, 4, word-offset width; LINE_BITS = 32*2**WORD_OFF_SIZE (512 default).
- TAG_SIZE, 20, tag width; TAG_SIZE+INDEX_SIZE+WORD_OFF_SIZE+2 must equal 32.
- NUM_WAYS, 2, associativity; power of two, 1..8; WAY_W = max(1, clog2(NUM_WAYS)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_en  in  1  lookup request.
- rd_index  in  INDEX_SIZE  lookup set.
- rd_tag  in  TAG_SIZE  lookup tag, compared one cycle later against the stored tags.
- resp_valid  out  1  lookup result valid, one cycle after an accepted rd_en.
- resp_hit  out  1  a valid way's tag matched.
- resp_way  out  WAY_W  matching way; 0 on miss.
- resp_line  out  LINE_BITS  line data of the matching way; all zero on miss.
- wr_en  in  1  refill write request.
- wr_index  in  INDEX_SIZE  refill set.
- wr_tag  in  TAG_SIZE  refill tag.
- wr_line  in  LINE_BITS  refill data.
- victim_way  out  WAY_W  combinational PLRU victim for wr_index; this is the way written when wr_en is high.
- flush_req  in  1  invalidate-all request (single-cycle pulse).
- flush_busy  out  1  flush sweep in progress.

Behaviour:
- Reset is asynchronous: valid[*][*]=0, PLRU bits=0, state=IDLE, flush counter=0, resp_valid=0, resp_hit=0, resp_way=0, resp_line=0, flush_busy=0. Tag/data arrays are not reset.
- Mid-flush reset forces IDLE immediately.
- Lookup: rd_en is accepted only in IDLE. At edge T the block registers the index, the tag and the per-way tag/data/valid read. During cycle T+1 resp_* present the compare result, so latency is 1 cycle.
  - A lookup can be issued every cycle.
  - resp_valid=0 in any cycle after no accepted rd_en.
- Hit: resp_hit=1 when exactly one way has valid && tag==rd_tag. If more than one way matches (illegal), the lowest way wins.
- PLRU update on a hit: at the end of the response cycle, mark resp_way most recently used in that set's tree.
- Refill: wr_en is accepted only in IDLE. At the edge it writes tag and line into way victim_way of wr_index, sets valid=1 and marks that way MRU.
- Same edge refill and lookup to the same set: the lookup returns the pre-write contents (read-before-write). The refill's PLRU update wins over a coincident hit update on the same set.
- NUM_WAYS=1: victim_way=0, no PLRU bits, resp_way=0.
- Tree PLRU per set: NUM_WAYS-1 bits. The victim walks the tree following the bit value (0=left). MRU update sets the bits along the path to point away from the accessed way.
- Flush state machine, IDLE -> FLUSH:
  - flush_req in IDLE: next edge enters FLUSH with counter=0 and flush_busy=1.
  - Each FLUSH cycle clears valid and PLRU of set counter and increments the counter.
  - After clearing set SETS-1 (counter wraps to 0) -> IDLE, flush_busy=0. Sweep length is SETS cycles.
  - In FLUSH: rd_en and wr_en are ignored (no write, resp_valid=0) and flush_req is ignored.
  - A response pending from the cycle before flush entry is still delivered.
  - flush_req coincident with rd_en/wr_en in IDLE: both the access and the flush entry take effect at that edge.

Decomposition:
- Package icache_pkg: default INDEX_SIZE/WORD_OFF_SIZE/TAG_SIZE/NUM_WAYS, LINE_BITS and WAY_W as functions of the parameters, and the flush-state enum (IDLE, FLUSH).
- One sub-module, icache_plru: per-set tree PLRU with parameter NUM_WAYS. Inputs are the current bits, an access way and an access valid. Outputs are the next bits and the victim.
- Tag/data arrays are per-way inferred register arrays inside the top module.

Test Plan:
- Reset, then rd_en index 5 tag 0x12345 -> next cycle resp_valid=1, resp_hit=0, resp_way=0, resp_line=0.
- NUM_WAYS=2: refill index 5 tag 0xAAAAA line L0 (victim 0), then tag 0xBBBBB line L1 (victim 1). Lookup 0xBBBBB -> hit way 1, line L1. Lookup 0xAAAAA -> hit way 0, line L0. victim_way(5) is now 1.
- Same cycle rd_en and wr_en to index 9, tag 0x00001 -> response is a miss. A lookup next cycle hits way 0.
- Fill all 64 sets, pulse flush_req -> flush_busy high for exactly 64 cycles. rd_en/wr_en during the sweep produce no response and no write. Afterwards every lookup misses and victim_way=0 for all sets.
- Assert reset at sweep cycle 20 -> flush_busy=0 and resp_valid=0 immediately. A lookup after release misses.
- NUM_WAYS=4: hit ways in order 0,1,2,3 on one set -> victim_way=0; then hit way 0 -> victim_way=2.
